// File: rtl/ads_adc_emu.sv
// ADS dual-channel serial ADC responder: BUSY timing, SDOA/SDOB readout, SDI config capture.
// Define ADS_EMU_RAMP_EN to source samples from an internal ramp instead of CH_A/CH_B_DATA.
module ads_adc_emu #(
  parameter int DATA_W      = 16,
  parameter int CONV_CYCLES = 40,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK_100M,
  input  logic              CLK_RST,
  input  logic [DATA_W-1:0] CH_A_DATA,
  input  logic [DATA_W-1:0] CH_B_DATA,
  input  logic              ADS_CLK,
  input  logic              ADS_CS_N,
  input  logic              ADS_CONVST,
  input  logic              ADS_RD,
  input  logic              ADS_SDI,
  input  logic [1:0]        ADS_M,
  output logic              ADS_BUSY,
  output logic              ADS_SDOA,
  output logic              ADS_SDOB,
  output logic [DATA_W-1:0] CFG_WORD,
  output logic              CFG_VALID,
  output logic [7:0]        OVR_CNT
);

  localparam int PW = 7;
  localparam int CW = $clog2(CONV_CYCLES + 1);
  localparam int BW = $clog2(2 * DATA_W + 1);
  localparam int SW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    READY,
    SHIFT
  } state_t;

  state_t state;
  state_t state_d;

  logic [PW-1:0] pin_raw;
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] s_new;
  logic [PW-1:0] lvl_q;

  logic clk_rise;
  logic clk_fall;
  logic cs_rise;
  logic cv_rise;

  logic [1:0] m_lvl;
  logic       cs_lvl;
  logic       rd_lvl;
  logic       sdi_lvl;

  logic [DATA_W-1:0]   src_a;
  logic [DATA_W-1:0]   src_b;
  logic [DATA_W-1:0]   samp_a;
  logic [DATA_W-1:0]   samp_b;
  logic                par_q;
  logic [CW-1:0]       conv_cnt;
  logic [2*DATA_W-1:0] sh_a;
  logic [DATA_W-1:0]   sh_b;
  logic [BW-1:0]       bit_cnt;
  logic [BW-1:0]       bit_total;
  logic [DATA_W-2:0]   sdi_sr;
  logic [SW-1:0]       sdi_cnt;

  logic accept;
  logic conv_done;
  logic ovr_inc;
  logic shift_go;
  logic shift_step;
  logic shift_stop;

  assign pin_raw = {ADS_M, ADS_CLK, ADS_CS_N,
                    ADS_CONVST, ADS_RD, ADS_SDI};
  assign s_new   = sync_q[SYNC_STAGES-1];

  assign m_lvl   = lvl_q[6:5];
  assign cs_lvl  = lvl_q[3];
  assign rd_lvl  = lvl_q[1];
  assign sdi_lvl = lvl_q[0];

  // Edge pulses are registered so every edge lands SYNC_STAGES+1 clocks in.
  always_ff @(posedge CLK_100M) begin
    if (CLK_RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      lvl_q    <= '0;
      clk_rise <= 1'b0;
      clk_fall <= 1'b0;
      cs_rise  <= 1'b0;
      cv_rise  <= 1'b0;
    end else begin
      sync_q[0] <= pin_raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      lvl_q    <= s_new;
      clk_rise <= s_new[4] & ~lvl_q[4];
      clk_fall <= ~s_new[4] & lvl_q[4];
      cs_rise  <= s_new[3] & ~lvl_q[3];
      cv_rise  <= s_new[2] & ~lvl_q[2];
    end
  end

`ifdef ADS_EMU_RAMP_EN
  logic [DATA_W-1:0] ramp_a;
  logic              unused_ch;

  assign unused_ch = ^{CH_A_DATA, CH_B_DATA};
  assign src_a     = ramp_a;
  assign src_b     = ~ramp_a;

  always_ff @(posedge CLK_100M) begin
    if (CLK_RST) begin
      ramp_a <= '0;
    end else if (accept) begin
      ramp_a <= ramp_a + 1'b1;
    end
  end
`else
  assign src_a = CH_A_DATA;
  assign src_b = CH_B_DATA;
`endif

  assign bit_total = par_q ? BW'(DATA_W) : BW'(2 * DATA_W);

  always_ff @(posedge CLK_100M) begin
    if (CLK_RST) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d    = state;
    accept     = 1'b0;
    conv_done  = 1'b0;
    ovr_inc    = 1'b0;
    shift_go   = 1'b0;
    shift_step = 1'b0;
    shift_stop = 1'b0;
    unique case (state)
      IDLE: begin
        if (cv_rise) begin
          accept  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        ovr_inc = cv_rise;
        if (conv_cnt == CW'(CONV_CYCLES - 1)) begin
          conv_done = 1'b1;
          state_d   = READY;
        end
      end
      READY: begin
        if (cv_rise) begin
          accept  = 1'b1;
          state_d = CONV;
        end else if (!cs_lvl && rd_lvl) begin
          shift_go = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        ovr_inc = cv_rise;
        // A CS_N rise beats a coincident ADS_CLK fall.
        if (cs_rise) begin
          shift_stop = 1'b1;
          state_d    = IDLE;
        end else if (clk_fall) begin
          if (bit_cnt == bit_total - 1'b1) begin
            shift_stop = 1'b1;
            state_d    = IDLE;
          end else begin
            shift_step = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_100M) begin
    if (CLK_RST) begin
      samp_a   <= '0;
      samp_b   <= '0;
      par_q    <= 1'b0;
      ADS_BUSY <= 1'b0;
      conv_cnt <= '0;
      sh_a     <= '0;
      sh_b     <= '0;
      bit_cnt  <= '0;
      ADS_SDOA <= 1'b0;
      ADS_SDOB <= 1'b0;
      OVR_CNT  <= '0;
    end else begin
      if (accept) begin
        samp_a <= src_a;
        samp_b <= src_b;
        par_q  <= (m_lvl != 2'b01);
      end
      if (accept) begin
        ADS_BUSY <= 1'b1;
        conv_cnt <= '0;
      end else begin
        if (conv_done) begin
          ADS_BUSY <= 1'b0;
        end
        if (state == CONV) begin
          conv_cnt <= conv_cnt + 1'b1;
        end
      end
      // sh_a holds {A,B} so serial mode simply runs past A into B.
      if (shift_go) begin
        sh_a     <= {samp_a, samp_b} << 1;
        sh_b     <= samp_b << 1;
        ADS_SDOA <= samp_a[DATA_W-1];
        ADS_SDOB <= par_q & samp_b[DATA_W-1];
        bit_cnt  <= '0;
      end else if (shift_step) begin
        sh_a     <= sh_a << 1;
        sh_b     <= sh_b << 1;
        ADS_SDOA <= sh_a[2*DATA_W-1];
        ADS_SDOB <= par_q & sh_b[DATA_W-1];
        bit_cnt  <= bit_cnt + 1'b1;
      end else if (shift_stop) begin
        sh_a     <= '0;
        sh_b     <= '0;
        ADS_SDOA <= 1'b0;
        ADS_SDOB <= 1'b0;
        bit_cnt  <= '0;
      end
      if (ovr_inc && OVR_CNT != 8'hFF) begin
        OVR_CNT <= OVR_CNT + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_100M) begin
    if (CLK_RST) begin
      sdi_sr    <= '0;
      sdi_cnt   <= '0;
      CFG_WORD  <= '0;
      CFG_VALID <= 1'b0;
    end else begin
      CFG_VALID <= 1'b0;
      if (cs_lvl) begin
        sdi_cnt <= '0;
      end else if (clk_rise) begin
        sdi_sr <= {sdi_sr[DATA_W-3:0], sdi_lvl};
        if (sdi_cnt == SW'(DATA_W - 1)) begin
          CFG_WORD  <= {sdi_sr, sdi_lvl};
          CFG_VALID <= 1'b1;
          sdi_cnt   <= '0;
        end else begin
          sdi_cnt <= sdi_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ads_adc_emu.sv
// Bench for ads_adc_emu: controller-side stimulus, sample/overrun/config model, per-cycle compare.
module tb_ads_adc_emu;

  localparam int W     = 16;
  localparam int CONVC = 40;
  localparam int SYNC  = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] ch_a = '0;
  logic [W-1:0] ch_b = '0;
  logic         ads_clk = 1'b0;
  logic         cs_n = 1'b1;
  logic         convst = 1'b0;
  logic         rd = 1'b0;
  logic         sdi = 1'b0;
  logic [1:0]   m = 2'b00;
  logic         busy;
  logic         sdoa;
  logic         sdob;
  logic [W-1:0] cfg_word;
  logic         cfg_valid;
  logic [7:0]   ovr_cnt;

  ads_adc_emu #(
    .DATA_W(W),
    .CONV_CYCLES(CONVC),
    .SYNC_STAGES(SYNC)
  ) dut (
    .CLK_100M(clk),
    .CLK_RST(rst),
    .CH_A_DATA(ch_a),
    .CH_B_DATA(ch_b),
    .ADS_CLK(ads_clk),
    .ADS_CS_N(cs_n),
    .ADS_CONVST(convst),
    .ADS_RD(rd),
    .ADS_SDI(sdi),
    .ADS_M(m),
    .ADS_BUSY(busy),
    .ADS_SDOA(sdoa),
    .ADS_SDOB(sdob),
    .CFG_WORD(cfg_word),
    .CFG_VALID(cfg_valid),
    .OVR_CNT(ovr_cnt)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int n_valid = 0;
  int exp_valid = 0;

  logic [7:0]   exp_ovr = '0;
  logic [W-1:0] exp_cfg = '0;
  logic [W-1:0] exp_a = '0;
  logic [W-1:0] exp_b = '0;
  logic [W-1:0] ramp_m = '0;
  logic [W-1:0] m_sr = '0;
  int           m_n = 0;
  bit           idle_chk = 1'b0;
  bit           sdob_zero = 1'b0;

  task automatic ck(input string nm, input logic [63:0] act,
                    input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic void m_rise(input logic b);
    m_sr = {m_sr[W-2:0], b};
    m_n++;
    if (m_n == W) begin
      exp_cfg = m_sr;
      exp_valid++;
      m_n = 0;
    end
  endfunction

  function automatic void m_accept(input logic [W-1:0] a,
                                   input logic [W-1:0] b);
`ifdef ADS_EMU_RAMP_EN
    exp_a  = ramp_m;
    exp_b  = ~ramp_m;
    ramp_m = ramp_m + 1'b1;
    if (a == b) exp_a = exp_a;
`else
    exp_a = a;
    exp_b = b;
`endif
  endfunction

  function automatic void m_reset();
    exp_ovr = '0;
    exp_cfg = '0;
    ramp_m  = '0;
    m_sr    = '0;
    m_n     = 0;
  endfunction

  // Outputs are compared 2 ns after the active edge; stimulus moves on negedges.
  always begin
    @(posedge clk);
    #2;
    if (cfg_valid) n_valid++;
    if (idle_chk) begin
      ck("idle_ovr", ovr_cnt, exp_ovr);
      ck("idle_cfg", cfg_word, exp_cfg);
      ck("idle_sdo", {sdoa, sdob}, 0);
      ck("idle_busy", busy, 0);
    end
    if (sdob_zero) ck("m01_sdob", sdob, 0);
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    idle_chk = 1'b0;
    rst = 1'b1;
    tick(3);
    ck("rst_busy", busy, 0);
    ck("rst_sdoa", sdoa, 0);
    ck("rst_sdob", sdob, 0);
    ck("rst_cfg", cfg_word, 0);
    ck("rst_valid", cfg_valid, 0);
    ck("rst_ovr", ovr_cnt, 0);
    rst = 1'b0;
    m_reset();
    tick(6);
    idle_chk = 1'b1;
  endtask

  task automatic start_conv(input logic [W-1:0] a,
                            input logic [W-1:0] b,
                            input logic [1:0] mm);
    idle_chk = 1'b0;
    ch_a = a;
    ch_b = b;
    m = mm;
    convst = 1'b1;
    tick(4);
    convst = 1'b0;
    m_accept(a, b);
    tick(2);
    ck("conv_busy_on", busy, 1);
  endtask

  // BUSY must appear SYNC+1 clocks after the sampling edge, i.e. at the
  // (SYNC+2)-th negedge after the pin is driven, and last CONVC clocks.
  task automatic conv_timed(input logic [W-1:0] a,
                            input logic [W-1:0] b,
                            input logic [1:0] mm);
    int k;
    int hi;
    idle_chk = 1'b0;
    ch_a = a;
    ch_b = b;
    m = mm;
    convst = 1'b1;
    k = 0;
    while (!busy && k < 20) begin
      tick(1);
      k++;
    end
    ck("busy_latency", k, SYNC + 2);
    convst = 1'b0;
    m_accept(a, b);
    hi = 0;
    while (busy && hi < 200) begin
      tick(1);
      hi++;
    end
    ck("busy_width", hi, CONVC);
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (busy && k < 100) begin
      tick(1);
      k++;
    end
    ck("busy_fall_bound", busy, 0);
    tick(2);
  endtask

  task automatic pulse_ovr();
    convst = 1'b1;
    tick(4);
    if (exp_ovr != 8'hFF) exp_ovr = exp_ovr + 1'b1;
    convst = 1'b0;
    tick(4);
  endtask

  task automatic do_read(input int nb, input int ovr_at, input bit m01,
                         output logic [63:0] wa, output logic [63:0] wb);
    wa = '0;
    wb = '0;
    sdob_zero = m01;
    cs_n = 1'b0;
    rd = 1'b1;
    tick(6);
    for (int i = 0; i < nb; i++) begin
      if (i == ovr_at) pulse_ovr();
      wa = {wa[62:0], sdoa};
      wb = {wb[62:0], sdob};
      ads_clk = 1'b1;
      m_rise(sdi);
      tick(10);
      ads_clk = 1'b0;
      tick(10);
    end
  endtask

  task automatic end_read();
    cs_n = 1'b1;
    rd = 1'b0;
    m_n = 0;
    tick(6);
    sdob_zero = 1'b0;
    idle_chk = 1'b1;
  endtask

  task automatic sdi_bits(input logic [W-1:0] w, input int n);
    idle_chk = 1'b0;
    cs_n = 1'b0;
    tick(4);
    for (int i = 0; i < n; i++) begin
      sdi = w[W-1-i];
      tick(3);
      ads_clk = 1'b1;
      m_rise(sdi);
      tick(5);
      ads_clk = 1'b0;
      tick(3);
    end
    tick(4);
    cs_n = 1'b1;
    m_n = 0;
    sdi = 1'b0;
    tick(6);
    idle_chk = 1'b1;
  endtask

  initial begin
    logic [63:0] wa;
    logic [63:0] wb;
    int          v0;
    logic [W-1:0] e;

    do_reset();

    conv_timed(16'hA5C3, 16'h1234, 2'b00);
    wait_ready();
    do_read(16, -1, 1'b0, wa, wb);
    ck("par_sdoa", wa[15:0], exp_a);
    ck("par_sdob", wb[15:0], exp_b);
`ifndef ADS_EMU_RAMP_EN
    ck("par_sdoa_lit", wa[15:0], 16'hA5C3);
    ck("par_sdob_lit", wb[15:0], 16'h1234);
`endif
    ck("par_end_sdo", {sdoa, sdob}, 0);
    end_read();

    start_conv(16'hA5C3, 16'h1234, 2'b01);
    wait_ready();
    do_read(32, -1, 1'b1, wa, wb);
    ck("ser_sdoa", wa[31:0], {exp_a, exp_b});
`ifndef ADS_EMU_RAMP_EN
    ck("ser_sdoa_lit", wa[31:0], 32'hA5C31234);
`endif
    ck("ser_sdob", wb[31:0], 0);
    ck("ser_end_sdo", {sdoa, sdob}, 0);
    end_read();

    start_conv(16'h5A3C, 16'h0F0F, 2'b10);
    repeat (3) pulse_ovr();
    wait_ready();
    do_read(16, 3, 1'b0, wa, wb);
    ck("ovr_sdoa", wa[15:0], exp_a);
    ck("ovr_sdob", wb[15:0], exp_b);
    ck("ovr_four", ovr_cnt, 8'd4);
    end_read();

    start_conv(16'h1111, 16'h2222, 2'b00);
    wait_ready();
    cs_n = 1'b0;
    rd = 1'b1;
    tick(6);
    repeat (300) pulse_ovr();
    ck("ovr_sat", ovr_cnt, 8'd255);
    ck("ovr_model", ovr_cnt, exp_ovr);
    end_read();

    start_conv(16'hA5C3, 16'h1234, 2'b00);
    wait_ready();
    do_read(7, -1, 1'b0, wa, wb);
    cs_n = 1'b1;
    rd = 1'b0;
    m_n = 0;
    tick(6);
    ck("abort_sdo", {sdoa, sdob}, 0);
    ck("abort_bits", wa[6:0], exp_a[15:9]);
`ifndef ADS_EMU_RAMP_EN
    ck("abort_bits_lit", wa[6:0], 7'h52);
`endif
    end_read();
    start_conv(16'h00FF, 16'h1234, 2'b00);
    wait_ready();
    do_read(16, -1, 1'b0, wa, wb);
    ck("after_abort_a", wa[15:0], exp_a);
`ifndef ADS_EMU_RAMP_EN
    ck("after_abort_lit", wa[15:0], 16'h00FF);
`endif
    end_read();

    v0 = n_valid;
    sdi_bits(16'hC00D, 16);
    ck("cfg_word", cfg_word, 16'hC00D);
    ck("cfg_valid_once", n_valid - v0, 1);
    v0 = n_valid;
    sdi_bits(16'hFFFF, 9);
    ck("cfg_partial_hold", cfg_word, 16'hC00D);
    ck("cfg_partial_novalid", n_valid - v0, 0);
    ck("cfg_valid_total", n_valid, exp_valid);

`ifdef ADS_EMU_RAMP_EN
    do_reset();
    for (int i = 0; i < 3; i++) begin
      start_conv(16'hFFFF, 16'h0000, 2'b00);
      wait_ready();
      do_read(16, -1, 1'b0, wa, wb);
      e = 16'(i);
      ck("ramp_a", wa[15:0], e);
      e = ~e;
      ck("ramp_b", wb[15:0], e);
      end_read();
    end
    start_conv(16'h0, 16'h0, 2'b00);
    tick(10);
    rst = 1'b1;
    tick(1);
    ck("rst_mid_busy", busy, 0);
    tick(2);
    rst = 1'b0;
    m_reset();
    tick(6);
    idle_chk = 1'b1;
    start_conv(16'h0, 16'h0, 2'b00);
    wait_ready();
    do_read(16, -1, 1'b0, wa, wb);
    ck("ramp_restart_a", wa[15:0], 16'h0000);
    ck("ramp_restart_b", wb[15:0], 16'hFFFF);
    end_read();
`else
    e = '0;
    if (e != 0) $display("unreachable");
`endif

    tick(4);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
